temp_project_top: RTL and testbench

Top level of the temperature/humidity readout project. It contains an on-chip sensor model that produces a new temperature and humidity reading every sample period. Each reading is formatted as binary plus packed-BCD display words and as two 16-character ASCII text lines for a character LCD. The block has no sensor pins; the only inputs are clock and reset.

---
 rtl/temp_project_pkg.sv | 59 +++++
 rtl/temp_project_sensor_model.sv | 60 ++++++
 rtl/temp_project_top.sv | 65 ++++++
 tb/tb_temp_project_top.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/temp_project_pkg.sv
// Shared constants, payload types and formatting helpers for the
// temperature/humidity readout.
//   bin_to_bcd2 : 8-bit binary (0..99) -> packed two-digit BCD
//   make_line   : 6-char prefix + two digits + " " + unit char + 6 spaces
package temp_project_pkg;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned DISP_W = 16;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned PFX_W  = 48;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_PCT   = 8'h25;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  // "TEMP: " and "HUM:  "
  localparam logic [PFX_W-1:0] TEMP_PREFIX =
    {8'h54, 8'h45, 8'h4D, 8'h50, ASCII_COLON, ASCII_SPACE};
  localparam logic [PFX_W-1:0] HUM_PREFIX =
    {8'h48, 8'h55, 8'h4D, ASCII_COLON, ASCII_SPACE, ASCII_SPACE};

  localparam logic [BIN_W-1:0] TEMP_RST = 8'd25;
  localparam logic [BIN_W-1:0] HUM_RST  = 8'd60;

  // Display word: BCD tens, BCD units, binary value
  typedef struct packed {
    logic [3:0]       tens;
    logic [3:0]       units;
    logic [BIN_W-1:0] bin;
  } disp_t;

  // Inputs are always <= 99, so two BCD digits suffice
  function automatic logic [7:0] bin_to_bcd2(input logic [BIN_W-1:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  function automatic disp_t make_disp(input logic [BIN_W-1:0] v);
    disp_t d;
    logic [7:0] bcd;
    bcd     = bin_to_bcd2(v);
    d.tens  = bcd[7:4];
    d.units = bcd[3:0];
    d.bin   = v;
    return d;
  endfunction

  function automatic logic [LINE_W-1:0] make_line(input logic [PFX_W-1:0] prefix,
                                                  input disp_t            d,
                                                  input logic [7:0]       unit_ch);
    return {prefix,
            ASCII_ZERO + 8'(d.tens),
            ASCII_ZERO + 8'(d.units),
            ASCII_SPACE, unit_ch,
            {6{ASCII_SPACE}}};
  endfunction

endpackage

// File: rtl/temp_project_sensor_model.sv
// On-chip sensor model: sample timer plus rising temperature sawtooth and
// falling humidity sawtooth, both advanced once per sample period.
//   clk, rst : clock, synchronous active-high reset
//   temp     : current temperature reading (binary)
//   hum      : current humidity reading (binary)
//   upd      : one-cycle pulse, high in the cycle the new reading is valid
module temp_sensor_model
  import temp_project_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = 50_000_000,
  parameter int unsigned T_MIN         = 20,
  parameter int unsigned T_MAX         = 35,
  parameter int unsigned H_MIN         = 40,
  parameter int unsigned H_MAX         = 80,
  parameter int unsigned H_STEP        = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [BIN_W-1:0] temp,
  output logic [BIN_W-1:0] hum,
  output logic             upd
);

  localparam int unsigned CNT_W = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick_c;
  logic [BIN_W-1:0] temp_nxt_c;
  logic [BIN_W-1:0] hum_nxt_c;

  assign tick_c = (cnt == CNT_W'(SAMPLE_CYCLES - 1));

  // Next readings; humidity compared at 9 bits so H_MIN+H_STEP cannot overflow
  always_comb begin
    temp_nxt_c = temp + 8'd1;
    hum_nxt_c  = hum - 8'(H_STEP);
    if (temp == 8'(T_MAX)) temp_nxt_c = 8'(T_MIN);
    if ({1'b0, hum} < 9'(H_MIN + H_STEP)) hum_nxt_c = 8'(H_MAX);
  end

  // Timer and sawtooth registers; upd follows the tick by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      temp <= TEMP_RST;
      hum  <= HUM_RST;
      upd  <= 1'b0;
    end else begin
      upd <= tick_c;
      if (tick_c) begin
        cnt  <= '0;
        temp <= temp_nxt_c;
        hum  <= hum_nxt_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/temp_project_top.sv
// Temperature/humidity readout top: sensor model plus registered display
// words and LCD text lines, all four refreshed together on each update.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   o_display_temp  : {tens BCD, units BCD, binary} temperature
//   o_display_humid : same layout for humidity
//   o_txt_line1     : "TEMP: nn C      " (char 0 in [127:120])
//   o_txt_line2     : "HUM:  nn %      "
module temp_project_top
  import temp_project_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = 50_000_000,
  parameter int unsigned T_MIN         = 20,
  parameter int unsigned T_MAX         = 35,
  parameter int unsigned H_MIN         = 40,
  parameter int unsigned H_MAX         = 80,
  parameter int unsigned H_STEP        = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [DISP_W-1:0] o_display_temp,
  output logic [DISP_W-1:0] o_display_humid,
  output logic [LINE_W-1:0] o_txt_line1,
  output logic [LINE_W-1:0] o_txt_line2
);

  logic [BIN_W-1:0] temp;
  logic [BIN_W-1:0] hum;
  logic             upd;
  disp_t            temp_disp_c;
  disp_t            hum_disp_c;

  temp_sensor_model #(
    .SAMPLE_CYCLES (SAMPLE_CYCLES),
    .T_MIN         (T_MIN),
    .T_MAX         (T_MAX),
    .H_MIN         (H_MIN),
    .H_MAX         (H_MAX),
    .H_STEP        (H_STEP)
  ) u_sensor (
    .clk  (i_clk),
    .rst  (i_rst),
    .temp (temp),
    .hum  (hum),
    .upd  (upd)
  );

  assign temp_disp_c = make_disp(temp);
  assign hum_disp_c  = make_disp(hum);

  // All four outputs load on the same edge so a reading is never mixed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_display_temp  <= make_disp(TEMP_RST);
      o_display_humid <= make_disp(HUM_RST);
      o_txt_line1     <= make_line(TEMP_PREFIX, make_disp(TEMP_RST), ASCII_C);
      o_txt_line2     <= make_line(HUM_PREFIX, make_disp(HUM_RST), ASCII_PCT);
    end else if (upd) begin
      o_display_temp  <= temp_disp_c;
      o_display_humid <= hum_disp_c;
      o_txt_line1     <= make_line(TEMP_PREFIX, temp_disp_c, ASCII_C);
      o_txt_line2     <= make_line(HUM_PREFIX, hum_disp_c, ASCII_PCT);
    end
  end

endmodule

// File: tb/tb_temp_project_top.sv
// Self-checking bench for temp_project_top with a short sample period.
// Expected readings are derived from the number of completed sample periods
// since the last reset release.
module tb_temp_project_top;

  localparam int SC     = 4;
  localparam int T_MIN  = 20;
  localparam int T_MAX  = 35;
  localparam int H_MIN  = 40;
  localparam int H_MAX  = 80;
  localparam int H_STEP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  disp_t_o;
  logic [15:0]  disp_h_o;
  logic [127:0] line1_o;
  logic [127:0] line2_o;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;   // rising edges since reset was last released

  always #5 clk = ~clk;

  temp_project_top #(
    .SAMPLE_CYCLES (SC),
    .T_MIN         (T_MIN),
    .T_MAX         (T_MAX),
    .H_MIN         (H_MIN),
    .H_MAX         (H_MAX),
    .H_STEP        (H_STEP)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_display_temp  (disp_t_o),
    .o_display_humid (disp_h_o),
    .o_txt_line1     (line1_o),
    .o_txt_line2     (line2_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] str_to_vec(input string s);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    return v;
  endfunction

  // Readings published so far: outputs reflect reading k after edge 1+k*SC
  function automatic int readings(input int e);
    return (e >= 1) ? (e - 1) / SC : 0;
  endfunction

  function automatic int model_temp(input int k);
    return T_MIN + ((25 - T_MIN + k) % (T_MAX - T_MIN + 1));
  endfunction

  function automatic int model_hum(input int k);
    int h;
    h = 60;
    for (int i = 0; i < k; i++) h = (h < H_MIN + H_STEP) ? H_MAX : h - H_STEP;
    return h;
  endfunction

  function automatic logic [15:0] word(input int v);
    return {4'(v / 10), 4'(v % 10), 8'(v)};
  endfunction

  // Compare all outputs against the model and internal consistency rules
  task automatic check_all();
    int k, t, h;
    logic [7:0] c6, c7;
    k = readings(edges);
    t = model_temp(k);
    h = model_hum(k);
    check("disp_temp", 128'(disp_t_o), 128'(word(t)));
    check("disp_humid", 128'(disp_h_o), 128'(word(h)));
    check("line1", line1_o, str_to_vec($sformatf("TEMP: %02d C      ", t)));
    check("line2", line2_o, str_to_vec($sformatf("HUM:  %02d %%      ", h)));
    check("temp_bin_vs_bcd", 128'(disp_t_o[7:0]),
          128'(10 * int'(disp_t_o[15:12]) + int'(disp_t_o[11:8])));
    check("hum_bin_vs_bcd", 128'(disp_h_o[7:0]),
          128'(10 * int'(disp_h_o[15:12]) + int'(disp_h_o[11:8])));
    c6 = line1_o[127-48 -: 8];
    c7 = line1_o[127-56 -: 8];
    check("line1_digits", 128'({c6, c7}),
          128'({8'h30 + 8'(disp_t_o[15:12]), 8'h30 + 8'(disp_t_o[11:8])}));
    c6 = line2_o[127-48 -: 8];
    c7 = line2_o[127-56 -: 8];
    check("line2_digits", 128'({c6, c7}),
          128'({8'h30 + 8'(disp_h_o[15:12]), 8'h30 + 8'(disp_h_o[11:8])}));
  endtask

  // Drive rst for one clock, advance the model, then sample on the falling edge
  task automatic run_cycle(input logic r);
    rst = r;
    @(posedge clk);
    if (r) edges = 0;
    else   edges++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);

    // Reset, release, and the first wraps
    for (int i = 0; i < 3; i++) run_cycle(1'b1);
    check("rst_temp", 128'(disp_t_o), 128'(16'h2519));
    check("rst_humid", 128'(disp_h_o), 128'(16'h603C));
    check("rst_line1", line1_o, str_to_vec("TEMP: 25 C      "));
    check("rst_line2", line2_o, str_to_vec("HUM:  60 %      "));
    for (int i = 1; i <= 60; i++) begin
      run_cycle(1'b0);
      if (i == 4) check("hold_temp", 128'(disp_t_o), 128'(16'h2519));
      if (i == 5) begin
        check("first_temp", 128'(disp_t_o), 128'(16'h261A));
        check("first_humid", 128'(disp_h_o), 128'(16'h583A));
      end
      if (i == 41) begin
        check("temp_max", 128'(disp_t_o), 128'(16'h3523));
        check("humid_min", 128'(disp_h_o), 128'(16'h4028));
      end
      if (i == 45) begin
        check("temp_wrap", 128'(disp_t_o), 128'(16'h2014));
        check("humid_wrap", 128'(disp_h_o), 128'(16'h8050));
        check("wrap_line1", line1_o, str_to_vec("TEMP: 20 C      "));
        check("wrap_line2", line2_o, str_to_vec("HUM:  80 %      "));
      end
    end

    // Mid-period reset after 2 ticks plus 2 cycles
    run_cycle(1'b1);
    for (int i = 0; i < 10; i++) run_cycle(1'b0);
    run_cycle(1'b1);
    check("mid_rst_temp", 128'(disp_t_o), 128'(16'h2519));
    for (int i = 1; i <= 12; i++) begin
      run_cycle(1'b0);
      if (i == 4) check("mid_hold", 128'(disp_t_o), 128'(16'h2519));
      if (i == 5) check("mid_update", 128'(disp_t_o), 128'(16'h261A));
    end

    // Reset in the same cycle the tick fires
    run_cycle(1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0);
    run_cycle(1'b1);
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b0);
      check("coll_humid", 128'(disp_h_o), 128'(16'h603C));
    end
    for (int i = 0; i < 10; i++) run_cycle(1'b0);

    // Long randomized run with sporadic resets of random length
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        int n;
        n = int'($urandom_range(1, 3));
        for (int j = 0; j < n; j++) run_cycle(1'b1);
      end else begin
        run_cycle(1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
